// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the ID instruction into an ALU control code, holds it in the
// ID/EX pipeline register, forwards EX/MEM and MEM/WB results onto the ALU operands and
// detects load-use hazards.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [31:0]      i_instr,
  input  logic [WIDTH-1:0] i_id_pc,
  input  logic [WIDTH-1:0] i_id_imm,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_exm_wr,
  input  logic [4:0]       i_exm_rd,
  input  logic [WIDTH-1:0] i_exm_data,
  input  logic             i_wb_wr,
  input  logic [4:0]       i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic             o_valid,
  output logic [3:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_op_0,
  output logic [WIDTH-1:0] o_op_1,
  output logic [WIDTH-1:0] o_store_data,
  output logic [4:0]       o_rd,
  output logic             o_reg_wr,
  output logic             o_is_load,
  output logic             o_is_store,
  output logic             o_is_branch,
  output logic             o_is_jump,
  output logic [2:0]       o_funct3,
  output logic             o_illegal,
  output logic             o_load_use_stall
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSltu = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluOr   = 4'b0101;
  localparam logic [3:0] AluAnd  = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  // Encoding 0 selects the register source so an all-zero bubble reads as rs=x0, data 0.
  typedef enum logic [1:0] {Op0Rs1, Op0Pc, Op0Zero} op0_sel_e;
  typedef enum logic [1:0] {Op1Rs2, Op1Imm, Op1Four} op1_sel_e;

  typedef struct packed {
    logic             valid;
    logic [3:0]       alu_ctrl;
    logic [4:0]       rd;
    logic             reg_wr;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jump;
    logic [2:0]       funct3;
    logic             illegal;
    op0_sel_e         op0_sel;
    op1_sel_e         op1_sel;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
  } idex_t;

  idex_t idex_q, idex_d, dec;
  logic  use_rs1, use_rs2;

  logic [6:0] opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic [2:0] id_f3;
  logic       id_alt;
  logic       unused_instr;

  assign opcode       = i_instr[6:0];
  assign id_rd        = i_instr[11:7];
  assign id_f3        = i_instr[14:12];
  assign id_rs1       = i_instr[19:15];
  assign id_rs2       = i_instr[24:20];
  assign id_alt       = i_instr[30];
  assign unused_instr = ^{i_instr[31], i_instr[29:25]};

  // Arithmetic/logic code shared by OP and OP-IMM; SUB exists only for register-register.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (is_reg && alt) ? AluSub : AluAdd;
      3'b001:  c = AluSll;
      3'b010:  c = AluSlt;
      3'b011:  c = AluSltu;
      3'b100:  c = AluXor;
      3'b101:  c = alt ? AluSra : AluSrl;
      3'b110:  c = AluOr;
      default: c = AluAnd;
    endcase
    return c;
  endfunction

  // Decode the ID instruction into the record the pipeline register would capture.
  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = i_id_valid;
    dec.funct3   = id_f3;
    dec.rs1_data = i_rs1_data;
    dec.rs2_data = i_rs2_data;
    dec.pc       = i_id_pc;
    dec.imm      = i_id_imm;
    case (opcode)
      OpcOp: begin
        dec.alu_ctrl = arith_ctrl(id_f3, id_alt, 1'b1);
        dec.reg_wr   = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OpcOpImm: begin
        dec.alu_ctrl = arith_ctrl(id_f3, id_alt, 1'b0);
        dec.op1_sel  = Op1Imm;
        dec.reg_wr   = 1'b1;
        use_rs1      = 1'b1;
      end
      OpcLui: begin
        dec.op0_sel = Op0Zero;
        dec.op1_sel = Op1Imm;
        dec.reg_wr  = 1'b1;
      end
      OpcAuipc: begin
        dec.op0_sel = Op0Pc;
        dec.op1_sel = Op1Imm;
        dec.reg_wr  = 1'b1;
      end
      OpcLoad: begin
        dec.op1_sel = Op1Imm;
        dec.reg_wr  = 1'b1;
        dec.is_load = 1'b1;
        use_rs1     = 1'b1;
      end
      OpcStore: begin
        dec.op1_sel  = Op1Imm;
        dec.is_store = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OpcBranch: begin
        case (id_f3[2:1])
          2'b10:   dec.alu_ctrl = AluSlt;
          2'b11:   dec.alu_ctrl = AluSltu;
          default: dec.alu_ctrl = AluSub;
        endcase
        dec.is_branch = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpcJal, OpcJalr: begin
        // Link value pc+4; rs1 of JALR still counts for hazard detection.
        dec.op0_sel = Op0Pc;
        dec.op1_sel = Op1Four;
        dec.reg_wr  = 1'b1;
        dec.is_jump = 1'b1;
        use_rs1     = (opcode == OpcJalr);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_wr = dec.reg_wr && (id_rd != 5'd0);
    dec.rd     = dec.reg_wr ? id_rd : 5'd0;
    dec.rs1    = use_rs1 ? id_rs1 : 5'd0;
    dec.rs2    = use_rs2 ? id_rs2 : 5'd0;
  end

  // Load in EX whose rd is read by the ID instruction; a flush cancels the request.
  always_comb begin
    o_load_use_stall = idex_q.valid && idex_q.is_load && (idex_q.rd != 5'd0) && i_id_valid &&
                       ((use_rs1 && (id_rs1 == idex_q.rd)) ||
                        (use_rs2 && (id_rs2 == idex_q.rd))) && !i_flush;
  end

  // Next ID/EX contents: flush, then hold on stall, then bubble on load-use, else advance.
  always_comb begin
    idex_d = dec;
    if (i_flush) begin
      idex_d = '0;
    end else if (i_stall) begin
      idex_d = idex_q;
    end else if (o_load_use_stall) begin
      idex_d = '0;
    end
  end

  // ID/EX pipeline register with synchronous reset to a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // Youngest producer wins; x0 is never forwarded.
  function automatic logic [WIDTH-1:0] fwd(input logic [4:0] rs, input logic [WIDTH-1:0] rf,
                                           input logic exm_wr, input logic [4:0] exm_rd,
                                           input logic [WIDTH-1:0] exm_data,
                                           input logic wb_wr, input logic [4:0] wb_rd,
                                           input logic [WIDTH-1:0] wb_data);
    logic [WIDTH-1:0] v;
    if (exm_wr && (exm_rd == rs) && (rs != 5'd0)) begin
      v = exm_data;
    end else if (wb_wr && (wb_rd == rs) && (rs != 5'd0)) begin
      v = wb_data;
    end else begin
      v = rf;
    end
    return v;
  endfunction

  logic [WIDTH-1:0] fwd_rs1, fwd_rs2, op1_raw;
  logic             is_shift;

  // Operand muxes from the register, with forwarding on register sources.
  always_comb begin
    fwd_rs1 = fwd(idex_q.rs1, idex_q.rs1_data, i_exm_wr, i_exm_rd, i_exm_data,
                  i_wb_wr, i_wb_rd, i_wb_data);
    fwd_rs2 = fwd(idex_q.rs2, idex_q.rs2_data, i_exm_wr, i_exm_rd, i_exm_data,
                  i_wb_wr, i_wb_rd, i_wb_data);
    case (idex_q.op0_sel)
      Op0Pc:   o_op_0 = idex_q.pc;
      Op0Zero: o_op_0 = '0;
      default: o_op_0 = fwd_rs1;
    endcase
    case (idex_q.op1_sel)
      Op1Imm:  op1_raw = idex_q.imm;
      Op1Four: op1_raw = WIDTH'(4);
      default: op1_raw = fwd_rs2;
    endcase
    is_shift = (idex_q.alu_ctrl == AluSll) || (idex_q.alu_ctrl == AluSrl) ||
               (idex_q.alu_ctrl == AluSra);
    o_op_1   = is_shift ? {{(WIDTH-5){1'b0}}, op1_raw[4:0]} : op1_raw;
  end

  assign o_store_data = fwd_rs2;
  assign o_valid      = idex_q.valid;
  assign o_alu_ctrl   = idex_q.alu_ctrl;
  assign o_rd         = idex_q.rd;
  assign o_reg_wr     = idex_q.reg_wr;
  assign o_is_load    = idex_q.is_load;
  assign o_is_store   = idex_q.is_store;
  assign o_is_branch  = idex_q.is_branch;
  assign o_is_jump    = idex_q.is_jump;
  assign o_funct3     = idex_q.funct3;
  assign o_illegal    = idex_q.illegal;

endmodule
